// File: rtl/sys_bus_interconnect_pkg.sv
// Shared definitions for the system bus interconnect: port count, index field
// position, port address width and the transaction FSM state type.
package sys_bus_pkg;

    localparam int NUM_PORTS = 8;
    localparam int IDX_LSB   = 20;
    localparam int IDX_MSB   = 22;
    localparam int IDX_W     = IDX_MSB - IDX_LSB + 1;
    localparam int PRT_AW    = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_PORTS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sys_bus_interconnect_if.sv
// Upstream (sys_*) and downstream broadcast (prt_*) bus bundles.
// Handshake: sys_wen_i/sys_ren_i are one-cycle request strobes, accepted only
// while idle; completion is a one-cycle sys_ack_o pulse with sys_err_o/sys_rdata_o
// valid only in that cycle. Ports see a one-cycle prt_wen_o/prt_ren_o strobe and
// answer with prt_ack_i (plus prt_err_i/read data) in any later cycle.
interface sys_bus_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = DW / 8
);
    logic [AW-1:0] sys_addr_i;
    logic [DW-1:0] sys_wdata_i;
    logic [SW-1:0] sys_sel_i;
    logic          sys_wen_i;
    logic          sys_ren_i;
    logic [DW-1:0] sys_rdata_o;
    logic          sys_err_o;
    logic          sys_ack_o;

    modport master (
        output sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i,
        input  sys_rdata_o, sys_err_o, sys_ack_o
    );

    modport slave (
        input  sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i,
        output sys_rdata_o, sys_err_o, sys_ack_o
    );
endinterface

interface prt_bus_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = DW / 8,
    parameter int NP = 8
);
    logic [AW-1:0]    prt_addr_o;
    logic [DW-1:0]    prt_wdata_o;
    logic [SW-1:0]    prt_sel_o;
    logic [NP-1:0]    prt_wen_o;
    logic [NP-1:0]    prt_ren_o;
    logic [NP*DW-1:0] prt_rdata_i;
    logic [NP-1:0]    prt_ack_i;
    logic [NP-1:0]    prt_err_i;

    modport master (
        output prt_addr_o, prt_wdata_o, prt_sel_o, prt_wen_o, prt_ren_o,
        input  prt_rdata_i, prt_ack_i, prt_err_i
    );

    modport slave (
        input  prt_addr_o, prt_wdata_o, prt_sel_o, prt_wen_o, prt_ren_o,
        output prt_rdata_i, prt_ack_i, prt_err_i
    );
endinterface

// File: rtl/sys_bus_interconnect_timeout.sv
// Loadable wait-cycle counter; expired flags the enabled cycle in which the
// count reaches LIMIT so the caller can leave its wait state on that edge.
module sys_bus_timeout #(
    parameter int W     = 8,
    parameter int LIMIT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign expired = en && (count == W'(LIMIT - 1));

endmodule

// File: rtl/sys_bus_interconnect.sv
// Single-outstanding system bus to eight-port interconnect: decodes the port
// from address bits [22:20], strobes it once and returns its ack/err/rdata.
module sys_bus_interconnect
    import sys_bus_pkg::*;
#(
    parameter int                   SYS_AW  = 32,
    parameter int                   SYS_DW  = 32,
    parameter int                   SYS_SW  = SYS_DW / 8,
    parameter logic [NUM_PORTS-1:0] PORT_EN = 8'hFF,
    parameter int                   TIMEOUT = 16
) (
    input  logic      sys_clk_i,
    input  logic      sys_rst_i,
    sys_bus_if.slave  sys,
    prt_bus_if.master prt,
    output state_t    dbg_state
);

    state_t                 state;
    logic [IDX_W-1:0]       idx_q;
    logic                   wr_q;
    logic [PRT_AW-1:0]      addr_q;
    logic [SYS_DW-1:0]      wdata_q;
    logic [SYS_SW-1:0]      sel_q;
    logic [NUM_PORTS-1:0]   wen_q;
    logic [NUM_PORTS-1:0]   ren_q;
    logic                   ack_q;
    logic                   err_q;
    logic [SYS_DW-1:0]      rdata_q;

    logic                   req;
    logic [IDX_W-1:0]       req_idx;
    logic [SYS_DW-1:0]      sel_rdata;
    logic                   tmo_clr;
    logic                   tmo_en;
    logic                   tmo_expired;
    logic                   unused_addr_hi;

    assign req            = sys.sys_wen_i | sys.sys_ren_i;
    assign req_idx        = sys.sys_addr_i[IDX_MSB:IDX_LSB];
    assign sel_rdata      = prt.prt_rdata_i[int'(idx_q) * SYS_DW +: SYS_DW];
    assign unused_addr_hi = ^sys.sys_addr_i[SYS_AW-1:IDX_MSB+1];

    assign tmo_clr = (state == ST_STROBE);
    assign tmo_en  = (state == ST_WAIT);

    sys_bus_timeout #(
        .W     (8),
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk      (sys_clk_i),
        .rst      (sys_rst_i),
        .clr      (tmo_clr),
        .load     (1'b0),
        .load_val (8'd0),
        .en       (tmo_en),
        .expired  (tmo_expired)
    );

    // Port strobes and the upstream response are registered one state ahead so
    // they are high exactly while the FSM sits in STROBE / RESP respectively.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state   <= ST_IDLE;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            wen_q   <= '0;
            ren_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            wen_q   <= '0;
            ren_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q  <= sys.sys_addr_i[PRT_AW-1:0];
                        wdata_q <= sys.sys_wdata_i;
                        sel_q   <= sys.sys_sel_i;
                        idx_q   <= req_idx;
                        wr_q    <= sys.sys_wen_i;
                        if (PORT_EN[req_idx]) begin
                            if (sys.sys_wen_i) wen_q <= port_onehot(req_idx);
                            else               ren_q <= port_onehot(req_idx);
                        end
                        state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (PORT_EN[idx_q]) begin
                        state <= ST_WAIT;
                    end else begin
                        ack_q <= 1'b1;
                        err_q <= 1'b1;
                        state <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    // A late ack still wins over an expiring counter.
                    if (prt.prt_ack_i[idx_q]) begin
                        ack_q   <= 1'b1;
                        err_q   <= prt.prt_err_i[idx_q];
                        rdata_q <= wr_q ? '0 : sel_rdata;
                        state   <= ST_RESP;
                    end else if (tmo_expired) begin
                        ack_q <= 1'b1;
                        err_q <= 1'b1;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sys.sys_ack_o   = ack_q;
    assign sys.sys_err_o   = err_q;
    assign sys.sys_rdata_o = rdata_q;

    assign prt.prt_addr_o  = {{(SYS_AW - PRT_AW){1'b0}}, addr_q};
    assign prt.prt_wdata_o = wdata_q;
    assign prt.prt_sel_o   = sel_q;
    assign prt.prt_wen_o   = wen_q;
    assign prt.prt_ren_o   = ren_q;

    assign dbg_state = state;

endmodule

// File: doc/sys_bus_interconnect.md
SYS_BUS_INTERCONNECT -- requirements
Module: sys_bus_interconnect

Interface
REQ-001 Parameter SYS_AW, default 32, system bus address width.
REQ-002 Parameter SYS_DW, default 32, system bus data width.
REQ-003 Parameter SYS_SW, default SYS_DW/8, byte-select width.
REQ-004 Parameter PORT_EN, default 8'hFF, bit n set = slave port n populated.
REQ-005 Parameter TIMEOUT, default 16, cycles to wait for a port ack before forcing an error (range 2..255).
REQ-006 sys_clk_i  in  1  single clock; all logic on its rising edge.
REQ-007 sys_rst_i  in  1  reset, synchronous, active-high.
REQ-008 sys_addr_i  in  SYS_AW  upstream address.
REQ-009 sys_wdata_i  in  SYS_DW  upstream write data.
REQ-010 sys_sel_i  in  SYS_SW  upstream byte select.
REQ-011 sys_wen_i / sys_ren_i  in  1 each  upstream write / read strobe, one cycle per request.
REQ-012 sys_rdata_o  out  SYS_DW  read data, valid with sys_ack_o.
REQ-013 sys_err_o / sys_ack_o  out  1 each  error flag / one-cycle completion pulse.
REQ-014 prt_addr_o  out  SYS_AW  latched address, broadcast to all ports, bits [19:0] only, upper bits zero.
REQ-015 prt_wdata_o / prt_sel_o  out  SYS_DW / SYS_SW  latched write data / byte select, broadcast.
REQ-016 prt_wen_o / prt_ren_o  out  8 each  per-port one-cycle write / read strobe.
REQ-017 prt_rdata_i  in  8*SYS_DW  port n read data in slice [n*SYS_DW +: SYS_DW].
REQ-018 prt_ack_i / prt_err_i  in  8 each  per-port acknowledge / error.

Function
REQ-019 Port index = sys_addr_i[22:20]; address bits above 22 ignored.
REQ-020 FSM states IDLE, STROBE, WAIT, RESP.
REQ-021 IDLE: sys_wen_i or sys_ren_i high -> latch address, data, select, index, direction; go STROBE; other upstream inputs ignored.
REQ-022 sys_wen_i and sys_ren_i high in the same cycle -> treated as write; read is dropped, no response for it.
REQ-023 STROBE (exactly one cycle): populated port -> assert prt_wen_o[idx] or prt_ren_o[idx] for this cycle only; go WAIT.
REQ-024 STROBE with PORT_EN[idx]=0 -> no port strobe; go RESP with err=1, rdata=0.
REQ-025 WAIT: prt_ack_i[idx] high -> capture prt_rdata_i slice (reads; 0 for writes) and prt_err_i[idx]; go RESP.
REQ-026 WAIT: ack/err of non-selected ports ignored; acks seen in STROBE/IDLE/RESP ignored.
REQ-027 Timeout counter cleared on entering WAIT, incremented each WAIT cycle; reaching TIMEOUT without ack -> go RESP with err=1, rdata=0.
REQ-028 Ack in the same cycle the counter reaches TIMEOUT -> ack wins, err = prt_err_i[idx].
REQ-029 RESP (one cycle): sys_ack_o=1, sys_err_o and sys_rdata_o from captured values; go IDLE.
REQ-030 sys_rdata_o and sys_err_o hold 0 whenever sys_ack_o=0.
REQ-031 Latency: request in cycle 0 -> port strobe cycle 1; port ack in cycle k -> sys_ack_o cycle k+1; minimum round trip 3 cycles (ack in cycle 2 -> sys_ack_o cycle 3).
REQ-032 Upstream strobes arriving outside IDLE are discarded, not queued.
REQ-033 prt_addr_o/prt_wdata_o/prt_sel_o stable from STROBE through RESP.

Reset
REQ-034 sys_rst_i high at any clock edge, including mid-transaction -> state IDLE, counter 0, all outputs 0 the next cycle; pending transaction abandoned without ack.
REQ-035 Strobes coincident with reset are discarded.

Structure
REQ-036 Shared package sys_bus_pkg holds state enum type, port count 8, index field position [22:20], port address width 20.
REQ-037 One sub-module sys_bus_timeout (loadable counter with clear/enable, expiry flag) is instantiated; decode and mux stay in the top.

Verification
REQ-038 Write 0x0030_0010 data 0xDEADBEEF, port 3 acks cycle 4 -> prt_wen_o=8'h08 cycle 1, prt_addr_o=0x00010, sys_ack_o cycle 5, sys_err_o=0.
REQ-039 Read 0x0010_0004, port 1 returns 0x12345678 ack cycle 2 -> sys_ack_o cycle 3, sys_rdata_o=0x12345678.
REQ-040 PORT_EN=8'h7F, read 0x0070_0000 -> no port strobe, sys_ack_o cycle 2, sys_err_o=1, sys_rdata_o=0.
REQ-041 Read port 2, no ack, TIMEOUT=16 -> sys_ack_o with sys_err_o=1 exactly once; later stray prt_ack_i[2] ignored.
REQ-042 sys_wen_i and sys_ren_i together to port 0 -> only prt_wen_o[0] pulses, one sys_ack_o; second strobe while WAIT -> discarded.
REQ-043 Reset asserted in WAIT -> all outputs 0 next cycle, no sys_ack_o; next request completes normally.
